// File: rtl/inst_enc.sv
// inst_enc: packs decoded RV32I fields into a 32-bit instruction word.
// Encoded words pass through a DEPTH-entry output FIFO; illegal requests are dropped and counted.
module inst_enc #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_fmt,
  input  logic [2:0]       in_funct3,
  input  logic [6:0]       in_funct7,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [4:0]       in_rd,
  input  logic [31:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_inst,
  output logic             err,
  output logic [CNT_W-1:0] emit_cnt,
  output logic [CNT_W-1:0] err_cnt
);
  localparam int AW = $clog2(DEPTH);
  logic [31:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] count;
  logic [31:0] last, word;
  logic [6:0] op;
  logic s12, s13, s21, bad, acc, push, pop;
  // sN: immediate fits an N-bit signed field
  assign s12 = &in_imm[31:11] | ~|in_imm[31:11];
  assign s13 = &in_imm[31:12] | ~|in_imm[31:12];
  assign s21 = &in_imm[31:20] | ~|in_imm[31:20];
  always_comb begin
    op = in_fmt == 3'd0 ? 7'h33 : in_fmt == 3'd1 ? 7'h13 : in_fmt == 3'd2 ? 7'h23 :
         in_fmt == 3'd3 ? 7'h63 : in_fmt == 3'd4 ? 7'h37 : 7'h6F;
    word = in_fmt == 3'd0 ? {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, op} :
           in_fmt == 3'd1 ? {in_imm[11:0], in_rs1, in_funct3, in_rd, op} :
           in_fmt == 3'd2 ? {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], op} :
           in_fmt == 3'd3 ? {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3, in_imm[4:1], in_imm[11], op} :
           in_fmt == 3'd4 ? {in_imm[31:12], in_rd, op} :
                            {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, op};
    bad = in_fmt > 3'd5
        | ((in_fmt == 3'd1 | in_fmt == 3'd2) & ~s12)
        | (in_fmt == 3'd3 & (in_imm[0] | ~s13))
        | (in_fmt == 3'd4 & |in_imm[11:0])
        | (in_fmt == 3'd5 & (in_imm[0] | ~s21));
  end
  assign in_ready  = count < (AW+1)'(DEPTH);
  assign out_valid = count != '0;
  assign acc       = in_valid & in_ready;
  assign push      = acc & ~bad;
  assign pop       = out_valid & out_ready;
  // last keeps the most recently popped word visible while the FIFO is empty
  assign out_inst  = out_valid ? mem[rp] : last;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wp <= '0;
      rp <= '0;
      count <= '0;
      last <= '0;
      err <= 1'b0;
      emit_cnt <= '0;
      err_cnt <= '0;
    end else begin
      if (push) begin
        mem[wp] <= word;
        wp <= wp + 1'b1;
      end
      if (pop) begin
        last <= mem[rp];
        rp <= rp + 1'b1;
        emit_cnt <= emit_cnt + 1'b1;
      end
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      err <= acc & bad;
      if (acc & bad) err_cnt <= err_cnt + 1'b1;
    end
endmodule

// File: tb/tb_inst_enc.sv
// tb_inst_enc: directed table of encode vectors plus hand-written FIFO and reset sequences.
module tb_inst_enc;
  logic clk = 0, rst_n = 0;
  logic in_valid = 0, in_ready, out_valid, out_ready = 1, err;
  logic [2:0] in_fmt = 0, in_funct3 = 0;
  logic [6:0] in_funct7 = 0;
  logic [4:0] in_rs1 = 0, in_rs2 = 0, in_rd = 0;
  logic [31:0] in_imm = 0, out_inst;
  logic [15:0] emit_cnt, err_cnt;
  int passed = 0, total = 0, n_emit = 0, n_err = 0;
  logic [31:0] last_w = 0;

  inst_enc #(.DEPTH(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_funct3(in_funct3), .in_funct7(in_funct7),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .err(err), .emit_cnt(emit_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] fmt; logic [2:0] f3; logic [6:0] f7;
    logic [4:0] rs1; logic [4:0] rs2; logic [4:0] rd;
    logic [31:0] imm; logic [31:0] exp; logic bad;
  } vec_t;

  vec_t tbl[$];
  vec_t wv[5];

  function automatic vec_t mk(input logic [2:0] fmt, f3, input logic [6:0] f7,
                              input logic [4:0] rs1, rs2, rd, input logic [31:0] imm, exp,
                              input logic bad);
    mk = '{fmt: fmt, f3: f3, f7: f7, rs1: rs1, rs2: rs2, rd: rd, imm: imm, exp: exp, bad: bad};
  endfunction

  task automatic drive(input vec_t x);
    in_fmt = x.fmt; in_funct3 = x.f3; in_funct7 = x.f7;
    in_rs1 = x.rs1; in_rs2 = x.rs2; in_rd = x.rd; in_imm = x.imm;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  initial begin
    tbl.push_back(mk(0, 0, 0, 1, 2, 3, 0, 32'h002081B3, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, -1, 32'hFFF00093, 0));
    tbl.push_back(mk(2, 2, 0, 1, 2, 0, 8, 32'h0020A423, 0));
    tbl.push_back(mk(4, 0, 0, 0, 0, 5, 32'h12345000, 32'h123452B7, 0));
    tbl.push_back(mk(3, 0, 0, 0, 0, 0, -4, 32'hFE000EE3, 0));
    tbl.push_back(mk(5, 0, 0, 0, 0, 1, 8, 32'h008000EF, 0));
    tbl.push_back(mk(3, 0, 0, 0, 0, 0, 3, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, -2048, 32'h80000013, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 2047, 32'h7FF00013, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 2048, 0, 1));
    tbl.push_back(mk(2, 0, 0, 0, 0, 0, -2049, 0, 1));
    tbl.push_back(mk(3, 0, 0, 0, 0, 0, 4094, 32'h7E000FE3, 0));
    tbl.push_back(mk(3, 0, 0, 0, 0, 0, 4096, 0, 1));
    tbl.push_back(mk(5, 0, 0, 0, 0, 0, 7, 0, 1));
    tbl.push_back(mk(5, 0, 0, 0, 0, 0, 1048576, 0, 1));
    tbl.push_back(mk(4, 0, 0, 0, 0, 0, 32'h00001001, 0, 1));
    tbl.push_back(mk(6, 0, 0, 0, 0, 0, 0, 0, 1));
    wv[0] = mk(1, 0, 0, 0, 0, 1, 1, 32'h00100093, 0);
    wv[1] = mk(1, 0, 0, 0, 0, 2, 2, 32'h00200113, 0);
    wv[2] = mk(1, 0, 0, 0, 0, 3, 3, 32'h00300193, 0);
    wv[3] = mk(1, 0, 0, 0, 0, 4, 4, 32'h00400213, 0);
    wv[4] = mk(1, 0, 0, 0, 0, 5, 5, 32'h00500293, 0);

    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_inst", out_inst, 0);
    chk("rst_err", err, 0);
    chk("rst_emit_cnt", emit_cnt, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_in_ready", in_ready, 1);
    @(negedge clk) rst_n = 1;

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i]);
      in_valid = 1;
      chk($sformatf("v%0d_in_ready", i), in_ready, 1);
      @(negedge clk);
      in_valid = 0;
      chk($sformatf("v%0d_out_valid", i), out_valid, !tbl[i].bad);
      chk($sformatf("v%0d_err", i), err, tbl[i].bad);
      chk($sformatf("v%0d_inst", i), out_inst, tbl[i].bad ? last_w : tbl[i].exp);
      if (tbl[i].bad) n_err++;
      else begin n_emit++; last_w = tbl[i].exp; end
      @(negedge clk);
      chk($sformatf("v%0d_drained", i), out_valid, 0);
      chk($sformatf("v%0d_err_pulse", i), err, 0);
      chk($sformatf("v%0d_emit_cnt", i), emit_cnt, n_emit);
      chk($sformatf("v%0d_err_cnt", i), err_cnt, n_err);
    end

    out_ready = 0;
    for (int k = 0; k < 5; k++) begin
      drive(wv[k]);
      in_valid = 1;
      chk($sformatf("fill%0d_in_ready", k), in_ready, k < 4);
      if (k > 0) chk($sformatf("fill%0d_head", k), out_inst, wv[0].exp);
      @(negedge clk);
    end
    chk("full_in_ready", in_ready, 0);
    chk("full_head", out_inst, wv[0].exp);
    @(negedge clk);
    chk("held_in_ready", in_ready, 0);
    chk("held_head", out_inst, wv[0].exp);
    out_ready = 1;
    @(negedge clk);
    chk("pop_no_push_head", out_inst, wv[1].exp);
    chk("pop_no_push_in_ready", in_ready, 1);
    for (int k = 2; k < 5; k++) begin
      @(negedge clk);
      in_valid = 0;
      chk($sformatf("drain%0d", k), out_inst, wv[k].exp);
      chk($sformatf("drain%0d_valid", k), out_valid, 1);
    end
    n_emit += 5;
    @(negedge clk);
    chk("drain_empty", out_valid, 0);
    chk("drain_hold", out_inst, wv[4].exp);
    chk("drain_emit_cnt", emit_cnt, n_emit);

    out_ready = 0;
    for (int k = 0; k < 3; k++) begin
      drive(wv[k]);
      in_valid = 1;
      @(negedge clk);
    end
    in_valid = 0;
    chk("pre_rst_valid", out_valid, 1);
    #2 rst_n = 0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_inst", out_inst, 0);
    chk("mid_rst_emit_cnt", emit_cnt, 0);
    chk("mid_rst_err_cnt", err_cnt, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1;
    out_ready = 1;
    @(negedge clk);
    drive(tbl[0]);
    in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    chk("post_rst_valid", out_valid, 1);
    chk("post_rst_inst", out_inst, tbl[0].exp);
    @(negedge clk);
    chk("post_rst_empty", out_valid, 0);
    chk("post_rst_emit_cnt", emit_cnt, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
